oram_requester: RTL and testbench
=================================

Name: oram_requester

Overview:
- Client-side initiator for the ORAM request interface: owns the other end of the rw_block_number / w_value / rw_indicator / input_ready -> r_value / output_ready handshake.
- Accepts CPU-side read/write commands through a valid/ready port and buffers them in a small FIFO.
- Issues commands to the ORAM one at a time, waits for completion with a timeout, and returns the response (read data or write ack) on a valid/ready response port.

Parameters:
- A, 8, bytes per block; data width is 8*A bits.
- D, 6, block-number width in bits.
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- TIMEOUT, 255, maximum WAIT cycles before a request is abandoned (1..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full.
- cmd_rw  in  1  0=read, 1=write.
- cmd_block  in  D  target block number.
- cmd_wdata  in  8*A  write data; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts response.
- rsp_rw  out  1  echo of the command's rw bit.
- rsp_rdata  out  8*A  read data; 0 for writes and for timeouts.
- rsp_timeout  out  1  request abandoned, no ORAM completion seen.
- busy  out  1  high in any state other than IDLE, or while the FIFO is non-empty.
- rw_block_number  out  D  to ORAM.
- w_value  out  8*A  to ORAM.
- rw_indicator  out  1  to ORAM.
- input_ready  out  1  to ORAM; one-cycle request strobe.
- r_value  in  8*A  from ORAM.
- output_ready  in  1  from ORAM; completion.

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE; FIFO is emptied; timeout counter is cleared.
  - All registered outputs go to 0: rsp_*, input_ready, rw_block_number, w_value, rw_indicator, busy.
  - cmd_ready reads 1 (FIFO empty).
  - A reset during WAIT drops the request silently; any later output_ready is ignored because the FSM is in IDLE.
- Command push: a command is written on a rising edge when cmd_valid && cmd_ready. While full, cmd_ready=0 and cmd_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head and register rw_indicator, rw_block_number and w_value (w_value forced to 0 for reads); go to ISSUE.
  - ISSUE: input_ready=1 for exactly this one cycle. Clear the counter; go to WAIT.
  - WAIT: input_ready=0; the ORAM-side outputs hold stable until RESP exits. Each cycle:
    - If output_ready=1: capture r_value (reads only) into rsp_rdata; rsp_timeout=0; go to RESP.
    - Else if counter == TIMEOUT-1: rsp_rdata=0, rsp_timeout=1; go to RESP.
    - Else increment the counter (8-bit, no wrap reachable).
  - RESP: rsp_valid=1, with rsp_rw, rsp_rdata and rsp_timeout stable. On rsp_ready=1, drop rsp_valid at the next edge and go to IDLE.
- Latency:
  - Command accepted at edge N into an empty FIFO with the FSM in IDLE: input_ready is high from edge N+1 to N+2; the ORAM samples it at edge N+2.
  - output_ready is sampled from edge N+3 onward.
  - If output_ready is seen at edge M, rsp_valid rises at edge M.
- output_ready is only sampled in WAIT; in IDLE, ISSUE and RESP it is ignored.
- Exactly one outstanding ORAM request at any time; responses return in command order.
- A push and a pop in the same cycle are both honoured; the FIFO count is unchanged.
- rsp_ready held low stalls the FSM indefinitely in RESP; the FIFO keeps accepting until full.

Decomposition:
- Shared package oram_pkg holds:
  - constants A, D, K;
  - typedef oram_cmd_t {rw, block[D-1:0], wdata[8*A-1:0]};
  - enum oram_req_state_t {IDLE, ISSUE, WAIT, RESP}.
- Sub-module oram_cmd_fifo: synchronous FIFO of oram_cmd_t, depth CMD_DEPTH, async active-low reset, full/empty flags, wrap-around pointers with an extra MSB for full/empty detection.

Test Plan:
- Reset, then a read of block 0x05; ORAM model asserts output_ready 3 cycles after input_ready with r_value=0x1122334455667788 -> one input_ready pulse, rw_indicator=0, rw_block_number=0x05; rsp_valid with rsp_rdata=0x1122334455667788, rsp_rw=0, rsp_timeout=0.
- Write block 0x3F with 0xDEADBEEFCAFEF00D, ORAM acks after 1 cycle -> w_value matches, rw_indicator=1; response rsp_rw=1, rsp_rdata=0, rsp_timeout=0.
- Push 5 commands back-to-back with ORAM stalled (CMD_DEPTH=4) -> cmd_ready drops after the FIFO holds 4 entries (one already popped into ISSUE/WAIT); all 5 complete in order once the ORAM responds.
- ORAM never responds, TIMEOUT=8 -> rsp_timeout=1, rsp_rdata=0 after 8 WAIT cycles; the next queued command is then issued normally.
- rsp_ready held low for 10 cycles -> rsp_valid and rsp_rdata stay stable and no new input_ready pulse occurs until the handshake.
- rst_n pulsed low mid-WAIT, with output_ready arriving afterwards -> all outputs 0, FIFO empty, cmd_ready=1, no rsp_valid generated.

Source files
------------

// File: rtl/oram_pkg.sv
// ---------------------------------------------------------------------------
// oram_pkg : shared constants, command record and requester state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package oram_pkg;
  localparam int A = 8;       // bytes per block
  localparam int D = 6;       // block-number width
  localparam int K = 8 * A;   // data width in bits

  typedef struct packed {
    logic         rw;
    logic [D-1:0] block;
    logic [K-1:0] wdata;
  } oram_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } oram_req_state_t;
endpackage

`default_nettype wire

// File: rtl/oram_requester_if.sv
// ---------------------------------------------------------------------------
// oram_requester_if : CPU command/response port plus ORAM request port
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface oram_requester_if;
  import oram_pkg::*;

  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_rw;
  logic [D-1:0] cmd_block;
  logic [K-1:0] cmd_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_rw;
  logic [K-1:0] rsp_rdata;
  logic         rsp_timeout;
  logic         busy;
  logic [D-1:0] rw_block_number;
  logic [K-1:0] w_value;
  logic         rw_indicator;
  logic         input_ready;
  logic [K-1:0] r_value;
  logic         output_ready;

  modport master (
    input  cmd_valid, cmd_rw, cmd_block, cmd_wdata, rsp_ready, r_value, output_ready,
    output cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_timeout, busy,
           rw_block_number, w_value, rw_indicator, input_ready
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_block, cmd_wdata, rsp_ready, r_value, output_ready,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_timeout, busy,
           rw_block_number, w_value, rw_indicator, input_ready
  );
endinterface

`default_nettype wire

// File: rtl/oram_cmd_fifo.sv
// ---------------------------------------------------------------------------
// oram_cmd_fifo : show-ahead command FIFO, extra pointer MSB tells full/empty
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oram_cmd_fifo
  import oram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  input  wire logic      i_push,
  input  wire oram_cmd_t i_data,
  input  wire logic      i_pop,
  output oram_cmd_t      o_data,
  output logic           o_full,
  output logic           o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  oram_cmd_t      r_mem [DEPTH];
  logic           w_push;
  logic           w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end
endmodule

`default_nettype wire

// File: rtl/oram_requester.sv
// ---------------------------------------------------------------------------
// oram_requester : queues CPU commands and issues them one at a time to the
//                  ORAM, returning read data, write acks or timeouts in order.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oram_requester
  import oram_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input wire logic         clk,
  input wire logic         rst_n,
  oram_requester_if.master bus
);
  localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

  oram_req_state_t r_state;
  oram_req_state_t w_state_next;
  oram_cmd_t       w_push_cmd;
  oram_cmd_t       w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic [7:0]      r_cnt;
  logic            r_input_ready;
  logic            r_rw_ind;
  logic [D-1:0]    r_blk;
  logic [K-1:0]    r_wval;
  logic            r_rsp_valid;
  logic            r_rsp_rw;
  logic [K-1:0]    r_rsp_rdata;
  logic            r_rsp_timeout;

  assign w_push_cmd = '{rw: bus.cmd_rw, block: bus.cmd_block, wdata: bus.cmd_wdata};

  oram_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.cmd_valid),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.cmd_ready       = !w_full;
  assign bus.busy            = (r_state != IDLE) || !w_empty;
  assign bus.input_ready     = r_input_ready;
  assign bus.rw_indicator    = r_rw_ind;
  assign bus.rw_block_number = r_blk;
  assign bus.w_value         = r_wval;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_rw          = r_rsp_rw;
  assign bus.rsp_rdata       = r_rsp_rdata;
  assign bus.rsp_timeout     = r_rsp_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (bus.output_ready || (r_cnt == c_LAST)) w_state_next = RESP;
      RESP:    if (bus.rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ORAM-side request fields are loaded only on pop, so they stay stable
  // through ISSUE, WAIT and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_input_ready <= 1'b0;
      r_rw_ind      <= 1'b0;
      r_blk         <= '0;
      r_wval        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rw      <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_input_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_rw_ind      <= w_head.rw;
            r_blk         <= w_head.block;
            r_wval        <= w_head.rw ? w_head.wdata : '0;
            r_input_ready <= 1'b1;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (bus.output_ready) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rw      <= r_rw_ind;
            r_rsp_rdata   <= r_rw_ind ? '0 : bus.r_value;
            r_rsp_timeout <= 1'b0;
          end else if (r_cnt == c_LAST) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rw      <= r_rw_ind;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP:    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_oram_requester.sv
// ---------------------------------------------------------------------------
// tb_oram_requester : random and directed traffic against a transaction-level
//                     model of the requester and a latency-programmable ORAM.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_oram_requester;
  import oram_pkg::*;

  localparam int T     = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic         rw;
    logic [D-1:0] blk;
    logic [K-1:0] wdata;
    int           k;      // ORAM completion seen k edges after request; 0 = never
    logic [K-1:0] rval;
  } stim_t;

  typedef struct {
    logic         rw;
    logic [K-1:0] rdata;
    logic         to;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oram_requester_if bus();

  oram_requester #(.CMD_DEPTH(DEPTH), .TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  stim_t pendq[$];
  stim_t fifoq[$];
  rsp_t  obs[$];
  stim_t cur;
  stim_t infl;
  rsp_t  exp_rsp;
  bit    cur_v, slot, accepted, popped_prev, exp_ready, saw_full;
  int    exp_rise, cyc, rem, n_ir, cmd_pct, rdy_pct;
  logic [K-1:0] rem_rval;
  logic  p_cmd_valid, p_rsp_valid, p_rsp_ready, p_rw, p_to;
  logic [K-1:0] p_rdata;

  task automatic check(string tag, logic [K-1:0] got, logic [K-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rw    = 1'($urandom_range(1));
    s.blk   = D'($urandom);
    s.wdata = {$urandom, $urandom};
    s.k     = int'($urandom_range(T + 2));
    s.rval  = {$urandom, $urandom};
    return s;
  endfunction

  function automatic stim_t mk(logic rw, logic [D-1:0] blk, logic [K-1:0] wd, int k, logic [K-1:0] rv);
    stim_t s;
    s.rw = rw; s.blk = blk; s.wdata = wd; s.k = k; s.rval = rv;
    return s;
  endfunction

  task automatic model_reset();
    fifoq.delete();
    pendq.delete();
    cur_v = 0; slot = 0; accepted = 0; popped_prev = 0; rem = 0; exp_ready = 1;
    p_cmd_valid = 0; p_rsp_valid = 0; p_rsp_ready = 0; p_rw = 0; p_to = 0; p_rdata = '0;
  endtask

  task automatic step();
    bit hs, pop_now, was_slot, exp_valid, ok;
    @(posedge clk);
    #1;
    cyc++;
    was_slot = slot;
    hs = p_rsp_valid && p_rsp_ready;
    if (hs) begin
      rsp_t r;
      r.rw = p_rw; r.rdata = p_rdata; r.to = p_to;
      obs.push_back(r);
      check("rsp_rw", p_rw, exp_rsp.rw);
      check("rsp_rdata", p_rdata, exp_rsp.rdata);
      check("rsp_timeout", p_to, exp_rsp.to);
      slot = 0;
      accepted = 0;
    end
    pop_now = !was_slot && (fifoq.size() > 0);
    if (pop_now) begin
      infl = fifoq.pop_front();
      slot = 1;
      accepted = 0;
    end
    if (p_cmd_valid && exp_ready) begin
      fifoq.push_back(cur);
      cur_v = 0;
    end
    if (popped_prev) begin
      ok = (infl.k >= 1) && (infl.k <= T);
      accepted = 1;
      exp_rise = cyc + (ok ? infl.k : T);
      exp_rsp.rw = infl.rw;
      exp_rsp.to = !ok;
      exp_rsp.rdata = (!ok || infl.rw) ? '0 : infl.rval;
      rem = infl.k;
      rem_rval = infl.rval;
    end else if (rem > 0) begin
      rem--;
    end
    popped_prev = pop_now;
    if (bus.input_ready) n_ir++;
    if (!bus.cmd_ready) saw_full = 1;

    check("input_ready", bus.input_ready, pop_now);
    if (slot) begin
      check("rw_indicator", bus.rw_indicator, infl.rw);
      check("rw_block_number", bus.rw_block_number, infl.blk);
      check("w_value", bus.w_value, infl.rw ? infl.wdata : '0);
    end
    exp_ready = fifoq.size() < DEPTH;
    check("cmd_ready", bus.cmd_ready, exp_ready);
    check("busy", bus.busy, slot || (fifoq.size() > 0));
    exp_valid = slot && accepted && (cyc >= exp_rise);
    check("rsp_valid", bus.rsp_valid, exp_valid);
    if (p_rsp_valid && !p_rsp_ready && bus.rsp_valid) begin
      check("hold_rw", bus.rsp_rw, p_rw);
      check("hold_rdata", bus.rsp_rdata, p_rdata);
      check("hold_timeout", bus.rsp_timeout, p_to);
    end

    if (!cur_v) begin
      if (pendq.size() > 0) begin
        cur = pendq.pop_front();
        cur_v = 1;
      end else if (int'($urandom_range(99)) < cmd_pct) begin
        cur = rand_stim();
        cur_v = 1;
      end
    end
    bus.cmd_valid    = cur_v;
    bus.cmd_rw       = cur.rw;
    bus.cmd_block    = cur.blk;
    bus.cmd_wdata    = cur.wdata;
    bus.rsp_ready    = int'($urandom_range(99)) < rdy_pct;
    bus.output_ready = (rem == 1) || (!slot && ($urandom_range(3) == 0));
    bus.r_value      = (rem == 1) ? rem_rval : {$urandom, $urandom};
    p_cmd_valid = cur_v;
    p_rsp_valid = bus.rsp_valid;
    p_rsp_ready = bus.rsp_ready;
    p_rw        = bus.rsp_rw;
    p_rdata     = bus.rsp_rdata;
    p_to        = bus.rsp_timeout;
  endtask

  task automatic wait_idle(string tag, int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      done = !slot && (fifoq.size() == 0) && !cur_v && (pendq.size() == 0);
    end
    check({tag, "_drained"}, done, 1'b1);
  endtask

  task automatic check_rsp(string tag, int idx, logic rw, logic [K-1:0] rdata, logic to);
    check({tag, "_present"}, obs.size() > idx, 1'b1);
    if (obs.size() > idx) begin
      check({tag, "_rw"}, obs[idx].rw, rw);
      check({tag, "_rdata"}, obs[idx].rdata, rdata);
      check({tag, "_timeout"}, obs[idx].to, to);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_rw"}, bus.rsp_rw, 1'b0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, '0);
    check({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    check({tag, "_input_ready"}, bus.input_ready, 1'b0);
    check({tag, "_rw_block_number"}, bus.rw_block_number, '0);
    check({tag, "_w_value"}, bus.w_value, '0);
    check({tag, "_rw_indicator"}, bus.rw_indicator, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int n0, i0;
    bus.cmd_valid = 0; bus.cmd_rw = 0; bus.cmd_block = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 0; bus.output_ready = 0; bus.r_value = '0;
    cyc = 0; n_ir = 0; saw_full = 0; cmd_pct = 0; rdy_pct = 100;
    cur = mk(0, '0, '0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1;

    // Read of block 0x05, ORAM completes 3 cycles after the request
    n0 = n_ir; i0 = obs.size();
    pendq.push_back(mk(0, 6'h05, 64'hA5A5_A5A5_A5A5_A5A5, 3, 64'h1122334455667788));
    wait_idle("t1", 60);
    check("t1_pulses", n_ir - n0, 1);
    check_rsp("t1", i0, 1'b0, 64'h1122334455667788, 1'b0);

    // Write of block 0x3F, ack after 1 cycle
    n0 = n_ir; i0 = obs.size();
    pendq.push_back(mk(1, 6'h3F, 64'hDEADBEEFCAFEF00D, 1, 64'h0123456789ABCDEF));
    wait_idle("t2", 60);
    check("t2_pulses", n_ir - n0, 1);
    check_rsp("t2", i0, 1'b1, '0, 1'b0);

    // Five back-to-back commands against a slow ORAM fill the FIFO
    saw_full = 0; i0 = obs.size();
    for (int i = 0; i < 5; i++)
      pendq.push_back(mk(1'(i & 1), D'(i + 10), {$urandom, $urandom}, T, {$urandom, $urandom}));
    wait_idle("t3", 200);
    check("t3_full_seen", saw_full, 1'b1);
    check("t3_count", obs.size() - i0, 5);

    // No ORAM completion: timeout, then the next command runs normally
    i0 = obs.size();
    pendq.push_back(mk(0, 6'h21, '0, 0, 64'hFFFF_0000_FFFF_0000));
    pendq.push_back(mk(0, 6'h22, '0, 2, 64'h0F0F_0F0F_1234_5678));
    wait_idle("t4", 100);
    check_rsp("t4a", i0, 1'b0, '0, 1'b1);
    check_rsp("t4b", i0 + 1, 1'b0, 64'h0F0F_0F0F_1234_5678, 1'b0);

    // Completion one edge past the window is ignored -> timeout
    i0 = obs.size();
    pendq.push_back(mk(0, 6'h23, '0, T + 1, 64'h7777_7777_7777_7777));
    wait_idle("t4c", 60);
    check_rsp("t4c", i0, 1'b0, '0, 1'b1);

    // rsp_ready held low: response stays put, no second request issued
    n0 = n_ir; rdy_pct = 0;
    pendq.push_back(mk(0, 6'h31, '0, 2, 64'hCAFE_0000_BABE_0001));
    pendq.push_back(mk(1, 6'h32, 64'h5555_AAAA_5555_AAAA, 2, '0));
    repeat (20) step();
    check("t5_pulses_stalled", n_ir - n0, 1);
    check("t5_valid_held", bus.rsp_valid, 1'b1);
    rdy_pct = 100;
    wait_idle("t5", 60);
    check("t5_pulses_total", n_ir - n0, 2);

    // Random traffic
    cmd_pct = 40; rdy_pct = 70;
    repeat (400) step();
    cmd_pct = 0; rdy_pct = 100;
    wait_idle("rand", 400);

    // Reset in the middle of WAIT, with a completion arriving afterwards
    i0 = obs.size();
    pendq.push_back(mk(0, 6'h2A, '0, 0, '0));
    for (int i = 0; i < 20 && !accepted; i++) step();
    check("t6_accepted", accepted, 1'b1);
    repeat (3) step();
    #2;
    rst_n = 0;
    #1;
    check_idle_outputs("t6_rst");
    bus.cmd_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    bus.output_ready = 1;
    bus.r_value = 64'h9999_8888_7777_6666;
    repeat (10) step();
    check("t6_no_rsp", obs.size() - i0, 0);
    check("t6_rsp_valid", bus.rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
